// File: rtl/stopwatch_core.sv
// Stopwatch core: counts SS.CC in BCD on rising edges of a 100 Hz tick while
// running, with start/stop and clear buttons and a sticky wrap flag.
module stopwatch_core #(
  parameter int MAX_SEC = 59
) (
  input  logic       clk100MHz,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones,
  output logic       running,
  output logic       ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] MAX_TENS = 4'(MAX_SEC / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_SEC % 10);

  state_e     state_q, state_d;
  logic       tick_dly_q, ss_dly_q, clr_dly_q;
  logic       tick_rise, ss_rise, clr_rise;
  logic [3:0] sec_tens_q, sec_ones_q, cs_tens_q, cs_ones_q;
  logic [3:0] sec_tens_d, sec_ones_d, cs_tens_d, cs_ones_d;
  logic       ovf_q, ovf_d;
  logic       running_q, running_d;
  logic       inc;
  logic       at_max;

  assign tick_rise = tick_in & ~tick_dly_q;
  assign ss_rise   = btn_start_stop & ~ss_dly_q;
  assign clr_rise  = btn_clear & ~clr_dly_q;

  // Delay registers reset high so inputs already asserted at reset release are not events.
  always_ff @(posedge clk100MHz) begin
    if (!rst_n) begin
      tick_dly_q <= 1'b1;
      ss_dly_q   <= 1'b1;
      clr_dly_q  <= 1'b1;
    end else begin
      tick_dly_q <= tick_in;
      ss_dly_q   <= btn_start_stop;
      clr_dly_q  <= btn_clear;
    end
  end

  always_ff @(posedge clk100MHz) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_rise) begin
      state_d = ST_IDLE;
    end else if (ss_rise) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // running is registered alongside the state so it tracks RUN exactly.
  always_comb begin
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk100MHz) begin
    if (!rst_n) begin
      running_q <= 1'b0;
    end else begin
      running_q <= running_d;
    end
  end

  // The increment decision uses the pre-transition state.
  assign inc    = tick_rise & (state_q == ST_RUN);
  assign at_max = (sec_tens_q == MAX_TENS) && (sec_ones_q == MAX_ONES) &&
                  (cs_tens_q == 4'd9) && (cs_ones_q == 4'd9);

  always_comb begin
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    cs_tens_d  = cs_tens_q;
    cs_ones_d  = cs_ones_q;
    ovf_d      = ovf_q;
    if (clr_rise) begin
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
      cs_tens_d  = 4'd0;
      cs_ones_d  = 4'd0;
      ovf_d      = 1'b0;
    end else if (inc && at_max) begin
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
      cs_tens_d  = 4'd0;
      cs_ones_d  = 4'd0;
      ovf_d      = 1'b1;
    end else if (inc) begin
      if (cs_ones_q != 4'd9) begin
        cs_ones_d = cs_ones_q + 4'd1;
      end else begin
        cs_ones_d = 4'd0;
        if (cs_tens_q != 4'd9) begin
          cs_tens_d = cs_tens_q + 4'd1;
        end else begin
          cs_tens_d = 4'd0;
          if (sec_ones_q != 4'd9) begin
            sec_ones_d = sec_ones_q + 4'd1;
          end else begin
            sec_ones_d = 4'd0;
            sec_tens_d = sec_tens_q + 4'd1;
          end
        end
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk100MHz) begin
    if (!rst_n) begin
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      cs_tens_q  <= 4'd0;
      cs_ones_q  <= 4'd0;
      ovf_q      <= 1'b0;
    end else begin
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      cs_tens_q  <= cs_tens_d;
      cs_ones_q  <= cs_ones_d;
      ovf_q      <= ovf_d;
    end
  end

  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign cs_tens  = cs_tens_q;
  assign cs_ones  = cs_ones_q;
  assign running  = running_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: a behavioural centisecond model
// pushes expected {digits, running, ovf} vectors that are popped and compared.
module tb_stopwatch_core;

  localparam int MAX_SEC = 59;
  localparam int WRAP    = (MAX_SEC + 1) * 100;

  logic       clk100MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] sec_tens, sec_ones, cs_tens, cs_ones;
  logic       running, ovf;

  stopwatch_core #(.MAX_SEC(MAX_SEC)) dut (
    .clk100MHz(clk100MHz), .rst_n(rst_n), .tick_in(tick_in),
    .btn_start_stop(btn_start_stop), .btn_clear(btn_clear),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .cs_tens(cs_tens), .cs_ones(cs_ones),
    .running(running), .ovf(ovf)
  );

  always #5 clk100MHz = ~clk100MHz;

  logic [17:0] sb[$];
  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;
  int exp_state = 0;   // 0 idle, 1 run, 2 pause
  bit exp_ovf = 1'b0;

  function automatic logic [17:0] model_vec();
    int sec, cs;
    logic [3:0] st, so, ct, co;
    sec = exp_cnt / 100;
    cs  = exp_cnt % 100;
    st = 4'(sec / 10); so = 4'(sec % 10);
    ct = 4'(cs / 10);  co = 4'(cs % 10);
    return {st, so, ct, co, (exp_state == 1), exp_ovf};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {sec_tens, sec_ones, cs_tens, cs_ones, running, ovf};
  endfunction

  function automatic logic [17:0] mk(int st, int so, int ct, int co, bit r, bit o);
    logic [3:0] a, b, c, d;
    a = 4'(st); b = 4'(so); c = 4'(ct); d = 4'(co);
    return {a, b, c, d, r, o};
  endfunction

  task automatic drive_tick();
    tick_in = 1'b1;
    @(posedge clk100MHz); #1;
    if (exp_state == 1) begin
      exp_cnt = (exp_cnt + 1) % WRAP;
      if (exp_cnt == 0) exp_ovf = 1'b1;
    end
    sb.push_back(model_vec());
    tick_in = 1'b0;
    @(posedge clk100MHz); #1;
  endtask

  task automatic press_ss(int hold);
    btn_start_stop = 1'b1;
    repeat (hold) begin
      @(posedge clk100MHz); #1;
    end
    case (exp_state)
      0: exp_state = 1;
      1: exp_state = 2;
      default: exp_state = 1;
    endcase
    sb.push_back(model_vec());
    btn_start_stop = 1'b0;
    @(posedge clk100MHz); #1;
  endtask

  task automatic press_clr();
    btn_clear = 1'b1;
    @(posedge clk100MHz); #1;
    exp_cnt = 0; exp_state = 0; exp_ovf = 1'b0;
    sb.push_back(model_vec());
    btn_clear = 1'b0;
    @(posedge clk100MHz); #1;
  endtask

  task automatic test_reset();
    logic [17:0] e;
    rst_n = 1'b0;
    repeat (3) @(posedge clk100MHz);
    #1;
    sb.push_back(model_vec());
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== e) begin miscompares++; $display("FAIL reset_hold got %h want %h", dut_vec(), e); end
    rst_n = 1'b1;
    @(posedge clk100MHz); #1;
    sb.push_back(model_vec());
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== mk(0, 0, 0, 0, 1'b0, 1'b0) || dut_vec() !== e) begin
      miscompares++; $display("FAIL reset_release got %h want %h", dut_vec(), e);
    end
  endtask

  task automatic test_count150();
    logic [17:0] e;
    press_ss(1);
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== e) begin miscompares++; $display("FAIL start got %h want %h", dut_vec(), e); end
    for (int i = 0; i < 150; i++) begin
      drive_tick();
      e = sb.pop_front(); vectors++;
      if (dut_vec() !== e) begin miscompares++; $display("FAIL count150_tick%0d got %h want %h", i, dut_vec(), e); end
    end
    vectors++;
    if (dut_vec() !== mk(0, 1, 5, 0, 1'b1, 1'b0)) begin
      miscompares++; $display("FAIL count150_final got %h want %h", dut_vec(), mk(0, 1, 5, 0, 1'b1, 1'b0));
    end
  endtask

  task automatic test_pause();
    logic [17:0] e;
    press_clr();
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== e) begin miscompares++; $display("FAIL pause_clr got %h want %h", dut_vec(), e); end
    press_ss(1);
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== e) begin miscompares++; $display("FAIL pause_start got %h want %h", dut_vec(), e); end
    for (int i = 0; i < 1234; i++) begin
      drive_tick();
      e = sb.pop_front(); vectors++;
      if (dut_vec() !== e) begin miscompares++; $display("FAIL pause_run_tick%0d got %h want %h", i, dut_vec(), e); end
    end
    // held button for several cycles must pause exactly once
    press_ss(5);
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== mk(1, 2, 3, 4, 1'b0, 1'b0) || dut_vec() !== e) begin
      miscompares++; $display("FAIL pause_enter got %h want %h", dut_vec(), e);
    end
    for (int i = 0; i < 20; i++) begin
      drive_tick();
      e = sb.pop_front(); vectors++;
      if (dut_vec() !== e) begin miscompares++; $display("FAIL pause_hold_tick%0d got %h want %h", i, dut_vec(), e); end
    end
    press_ss(1);
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== e) begin miscompares++; $display("FAIL pause_resume got %h want %h", dut_vec(), e); end
    drive_tick();
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== mk(1, 2, 3, 5, 1'b1, 1'b0) || dut_vec() !== e) begin
      miscompares++; $display("FAIL pause_after got %h want %h", dut_vec(), e);
    end
  endtask

  task automatic test_wrap();
    logic [17:0] e;
    press_clr();
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== e) begin miscompares++; $display("FAIL wrap_clr got %h want %h", dut_vec(), e); end
    press_ss(1);
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== e) begin miscompares++; $display("FAIL wrap_start got %h want %h", dut_vec(), e); end
    for (int i = 0; i < 5999; i++) begin
      drive_tick();
      e = sb.pop_front(); vectors++;
      if (dut_vec() !== e) begin miscompares++; $display("FAIL wrap_run_tick%0d got %h want %h", i, dut_vec(), e); end
    end
    vectors++;
    if (dut_vec() !== mk(5, 9, 9, 9, 1'b1, 1'b0)) begin
      miscompares++; $display("FAIL wrap_max got %h want %h", dut_vec(), mk(5, 9, 9, 9, 1'b1, 1'b0));
    end
    drive_tick();
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== mk(0, 0, 0, 0, 1'b1, 1'b1) || dut_vec() !== e) begin
      miscompares++; $display("FAIL wrap_edge got %h want %h", dut_vec(), e);
    end
    for (int i = 0; i < 5; i++) begin
      drive_tick();
      e = sb.pop_front(); vectors++;
      if (dut_vec() !== e) begin miscompares++; $display("FAIL wrap_post_tick%0d got %h want %h", i, dut_vec(), e); end
    end
    vectors++;
    if (dut_vec() !== mk(0, 0, 0, 5, 1'b1, 1'b1)) begin
      miscompares++; $display("FAIL wrap_sticky got %h want %h", dut_vec(), mk(0, 0, 0, 5, 1'b1, 1'b1));
    end
  endtask

  task automatic test_priority();
    logic [17:0] e;
    for (int i = 0; i < 302; i++) begin
      drive_tick();
      e = sb.pop_front(); vectors++;
      if (dut_vec() !== e) begin miscompares++; $display("FAIL prio_run_tick%0d got %h want %h", i, dut_vec(), e); end
    end
    vectors++;
    if (dut_vec() !== mk(0, 3, 0, 7, 1'b1, 1'b1)) begin
      miscompares++; $display("FAIL prio_pre got %h want %h", dut_vec(), mk(0, 3, 0, 7, 1'b1, 1'b1));
    end
    btn_clear = 1'b1; btn_start_stop = 1'b1; tick_in = 1'b1;
    @(posedge clk100MHz); #1;
    exp_cnt = 0; exp_state = 0; exp_ovf = 1'b0;
    sb.push_back(model_vec());
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== mk(0, 0, 0, 0, 1'b0, 1'b0) || dut_vec() !== e) begin
      miscompares++; $display("FAIL prio_clear got %h want %h", dut_vec(), e);
    end
    btn_clear = 1'b0; btn_start_stop = 1'b0; tick_in = 1'b0;
    @(posedge clk100MHz); #1;
  endtask

  task automatic test_held_at_reset();
    logic [17:0] e;
    rst_n = 1'b0; tick_in = 1'b1; btn_start_stop = 1'b1;
    repeat (2) @(posedge clk100MHz);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0; exp_state = 0; exp_ovf = 1'b0;
    repeat (3) @(posedge clk100MHz);
    #1;
    sb.push_back(model_vec());
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== e) begin miscompares++; $display("FAIL held_release got %h want %h", dut_vec(), e); end
    tick_in = 1'b0; btn_start_stop = 1'b0;
    @(posedge clk100MHz); #1;
    drive_tick();
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== e) begin miscompares++; $display("FAIL held_idle_tick got %h want %h", dut_vec(), e); end
    press_ss(1);
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== e) begin miscompares++; $display("FAIL held_fresh_ss got %h want %h", dut_vec(), e); end
    drive_tick();
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== mk(0, 0, 0, 1, 1'b1, 1'b0) || dut_vec() !== e) begin
      miscompares++; $display("FAIL held_first_count got %h want %h", dut_vec(), e);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [17:0] e;
    for (int i = 0; i < 4566; i++) begin
      drive_tick();
      e = sb.pop_front(); vectors++;
      if (dut_vec() !== e) begin miscompares++; $display("FAIL midrst_run_tick%0d got %h want %h", i, dut_vec(), e); end
    end
    vectors++;
    if (dut_vec() !== mk(4, 5, 6, 7, 1'b1, 1'b0)) begin
      miscompares++; $display("FAIL midrst_pre got %h want %h", dut_vec(), mk(4, 5, 6, 7, 1'b1, 1'b0));
    end
    rst_n = 1'b0; tick_in = 1'b1; btn_start_stop = 1'b1;
    @(posedge clk100MHz); #1;
    exp_cnt = 0; exp_state = 0; exp_ovf = 1'b0;
    sb.push_back(model_vec());
    e = sb.pop_front(); vectors++;
    if (dut_vec() !== mk(0, 0, 0, 0, 1'b0, 1'b0) || dut_vec() !== e) begin
      miscompares++; $display("FAIL midrst_cleared got %h want %h", dut_vec(), e);
    end
    rst_n = 1'b1; tick_in = 1'b0; btn_start_stop = 1'b0;
    @(posedge clk100MHz); #1;
    for (int i = 0; i < 5; i++) begin
      drive_tick();
      e = sb.pop_front(); vectors++;
      if (dut_vec() !== e) begin miscompares++; $display("FAIL midrst_ignored_tick%0d got %h want %h", i, dut_vec(), e); end
    end
  endtask

  initial begin
    test_reset();
    test_count150();
    test_pause();
    test_wrap();
    test_priority();
    test_held_at_reset();
    test_reset_mid_run();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter MAX_SEC, default 59, SHALL set the highest seconds value before wrap; legal range 1..99.
REQ-002 Port clk100MHz  input  1  SHALL be the 100 MHz system clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 Port tick_in  input  1  SHALL be the 100 Hz divided square wave from the upstream divider, synchronous to clk100MHz.
REQ-005 Port btn_start_stop  input  1  SHALL be the start/stop request; debounced, synchronous level.
REQ-006 Port btn_clear  input  1  SHALL be the clear request; debounced, synchronous level.
REQ-007 Port sec_tens  output  4  SHALL be the BCD tens-of-seconds digit.
REQ-008 Port sec_ones  output  4  SHALL be the BCD ones-of-seconds digit.
REQ-009 Port cs_tens  output  4  SHALL be the BCD tenths-of-second digit.
REQ-010 Port cs_ones  output  4  SHALL be the BCD hundredths-of-second digit.
REQ-011 Port running  output  1  SHALL be high exactly while the FSM is in RUN.
REQ-012 Port ovf  output  1  SHALL be a sticky wrap flag.

Function
REQ-013 Edge detect: tick_rise, ss_rise, clr_rise SHALL each be asserted in a cycle where the input is 1 and its one-cycle-delayed register is 0.
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE.
REQ-015 Transitions: IDLE -ss_rise-> RUN; RUN -ss_rise-> PAUSE; PAUSE -ss_rise-> RUN; any state -clr_rise-> IDLE.
REQ-016 clr_rise SHALL take priority over ss_rise and tick_rise in the same cycle: digits 0, ovf 0, state IDLE.
REQ-017 Digits SHALL increment by one hundredth on the clock edge that ends a cycle with tick_rise=1 and current state RUN; no other condition increments.
REQ-018 Latency: tick_in sampled high (prior sample low) in cycle N SHALL yield updated digits visible in cycle N+1.
REQ-019 A tick_rise in the same cycle as ss_rise SHALL increment iff the current (pre-transition) state is RUN.
REQ-020 Carry chain: cs_ones 9->0 carries to cs_tens; cs_tens 9->0 carries to sec_ones; sec_ones 9->0 carries to sec_tens.
REQ-021 At MAX_SEC.99 the next increment SHALL wrap all digits to 00.00 and set ovf=1; counting continues.
REQ-022 ovf SHALL clear only on clr_rise or reset.
REQ-023 Digits SHALL hold unchanged in IDLE and PAUSE; PAUSE->RUN resumes from the held value.
REQ-024 Every digit SHALL stay within 0..9 (sec_tens within 0..MAX_SEC/10) at all times.
REQ-025 A held button SHALL produce only one event; the next event needs release and re-press.

Reset
REQ-026 While rst_n=0 at a clock edge: state IDLE, all digits 0, running 0, ovf 0.
REQ-027 Edge-detect delay registers SHALL reset to 1, so inputs already high at reset release produce no event.
REQ-028 Reset asserted mid-RUN SHALL override all inputs in that cycle; counting resumes only after a new ss_rise.

Verification
REQ-029 Reset, ss pulse, 150 tick_in periods -> digits 01.50, running=1.
REQ-030 RUN at 12.34, ss pulse, 20 ticks, ss pulse, 1 tick -> 12.34 held through pause, then 12.35.
REQ-031 MAX_SEC=59, RUN at 59.99, one tick -> 00.00, ovf=1; 5 more ticks -> 00.05, ovf still 1.
REQ-032 clr_rise, ss_rise and tick_rise in one cycle while RUN at 03.07 -> 00.00, IDLE, ovf=0.
REQ-033 tick_in and btn_start_stop held high through reset release -> no increment, state IDLE until a fresh rising edge.
REQ-034 rst_n low for one cycle during RUN at 45.67 -> next cycle 00.00, IDLE; subsequent ticks ignored.
